// File: rtl/random_pulse_generator.sv
// Pseudo-random pulse generator: a free-running 16-bit LFSR sets the low gap,
// uio_in sets pulse width and minimum gap, uo_out counts issued pulses.
module random_pulse_generator #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter logic [11:0] INIT_GAP = 12'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // One-hot so that any corrupted encoding is detectable and falls back to GAP.
    typedef enum logic [1:0] {
        ST_GAP   = 2'b01,
        ST_PULSE = 2'b10
    } state_t;

    state_t      state, state_next;
    logic [15:0] lfsr, lfsr_next;
    logic [11:0] gap_cnt, gap_next;
    logic [2:0]  width_cnt, width_next;
    logic [7:0]  count, count_next;
    logic        pulse, pulse_next;
    logic        fb;
    logic        cfg_unused;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= ST_GAP;
            lfsr      <= SEED;
            gap_cnt   <= INIT_GAP;
            width_cnt <= '0;
            count     <= '0;
            pulse     <= 1'b0;
        end else begin
            state     <= state_next;
            lfsr      <= lfsr_next;
            gap_cnt   <= gap_next;
            width_cnt <= width_next;
            count     <= count_next;
            pulse     <= pulse_next;
        end
    end

    always_comb begin
        fb         = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        lfsr_next  = (lfsr == '0) ? SEED : {lfsr[14:0], fb};

        state_next = ST_GAP;
        gap_next   = gap_cnt;
        width_next = width_cnt;
        count_next = count;

        case (state)
            ST_GAP: begin
                if (gap_cnt != '0) begin
                    gap_next = gap_cnt - 12'd1;
                end else begin
                    state_next = ST_PULSE;
                    width_next = uio_in[3:1];
                    count_next = count + 8'd1;
                end
            end
            ST_PULSE: begin
                if (width_cnt != '0) begin
                    state_next = ST_PULSE;
                    width_next = width_cnt - 3'd1;
                end else begin
                    state_next = ST_GAP;
                    gap_next   = {4'b0, uio_in[7:4], 4'b0} + {4'b0, lfsr[7:0]};
                end
            end
            default: begin
                state_next = ST_GAP;
            end
        endcase
    end

    // Pulse is a registered Moore output of the next state, so it can never glitch.
    always_comb begin
        pulse_next = (state_next == ST_PULSE);
        uo_out     = count;
        uio_out    = {7'b0, pulse};
        uio_oe     = 8'h01;
        cfg_unused = uio_in[0];
    end

endmodule

// File: tb/tb_random_pulse_generator.sv
// Self-checking bench: event-scheduled reference model plus table-driven
// width/gap checks and hand-written reset/config-change sequences.
module tb_random_pulse_generator;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    random_pulse_generator #(.SEED(SEED), .INIT_GAP(12'd15)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: tracks the edge number of the next pulse transition.
    logic [15:0] m_lfsr;
    logic        m_pulse;
    logic [7:0]  m_cnt;
    int          m_t;
    int          m_next;

    int          rises;
    logic        prev_pulse = 1'b0;
    logic [7:0]  prev_cnt = 8'd0;
    bit          wrapped = 1'b0;

    typedef struct {
        logic [7:0] cfg;
        int         width;
        int         gap_lo;
        int         gap_hi;
        int         npulses;
    } vec_t;

    vec_t vecs[3];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        if (l == 16'd0) return SEED;
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_lfsr  = SEED;
            m_pulse = 1'b0;
            m_cnt   = 8'd0;
            m_t     = 0;
            m_next  = 16;
            rises   = 0;
        end else begin
            m_t++;
            if (m_t == m_next) begin
                if (!m_pulse) begin
                    m_pulse = 1'b1;
                    m_cnt   = m_cnt + 8'd1;
                    m_next  = m_t + int'(uio_in[3:1]) + 1;
                end else begin
                    m_pulse = 1'b0;
                    m_next  = m_t + int'(uio_in[7:4]) * 16 + int'(m_lfsr[7:0]) + 1;
                end
            end
            m_lfsr = lfsr_step(m_lfsr);
        end
        #1;
        check("outputs", int'({uio_oe, uio_out, uo_out}), int'({8'h01, 7'b0, m_pulse, m_cnt}));
        if (uio_out[0] && !prev_pulse) rises++;
        if (prev_cnt == 8'd255 && uo_out == 8'd0) wrapped = 1'b1;
        prev_pulse = uio_out[0];
        prev_cnt   = uo_out;
    endtask

    task automatic wait_for(input logic level);
        int n = 0;
        while (uio_out[0] !== level && n < 2000) begin
            tick();
            n++;
        end
        if (uio_out[0] !== level) check("wait_timeout", 1, 0);
    endtask

    // Call right after a transition: returns how many cycles the level lasts.
    task automatic run_len(input logic level, output int len);
        len = 0;
        while (uio_out[0] === level && len < 2000) begin
            tick();
            len++;
        end
        if (len >= 2000) check("run_timeout", len, 0);
    endtask

    task automatic first_pulse_seq();
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("pre_first_low", int'(uio_out[0]), 0);
        end
        tick();
        check("first_rise", int'(uio_out[0]), 1);
        check("first_count", int'(uo_out), 1);
    endtask

    initial begin
        int w;
        int g;
        int n;
        logic [15:0] l;

        vecs[0] = '{cfg: 8'b0000_1110, width: 8, gap_lo: 1,   gap_hi: 256, npulses: 5};
        vecs[1] = '{cfg: 8'hF0,        width: 1, gap_lo: 241, gap_hi: 496, npulses: 5};
        vecs[2] = '{cfg: 8'h5A,        width: 6, gap_lo: 81,  gap_hi: 336, npulses: 5};

        // Reset and first-pulse latency with uio_in = 0.
        rst_n  = 1'b1;
        uio_in = 8'h00;
        tick();
        check("reset_count", int'(uo_out), 0);
        check("reset_pulse", int'(uio_out[0]), 0);
        rst_n = 1'b0;
        first_pulse_seq();
        tick();
        check("first_width1", int'(uio_out[0]), 0);

        // First gap with W=8 equals the reference LFSR low byte + 1.
        rst_n  = 1'b1;
        uio_in = 8'b0000_1110;
        tick();
        rst_n = 1'b0;
        wait_for(1'b1);
        run_len(1'b1, w);
        check("first_w8_width", w, 8);
        run_len(1'b0, g);
        l = SEED;
        repeat (23) l = lfsr_step(l);
        check("first_gap_lfsr", g, int'(l[7:0]) + 1);

        // Table-driven width/gap ranges; a fall after cfg change starts the new regime.
        foreach (vecs[k]) begin
            uio_in = vecs[k].cfg;
            wait_for(1'b1);
            wait_for(1'b0);
            for (int p = 0; p < vecs[k].npulses; p++) begin
                run_len(1'b0, g);
                check_range("gap_range", g, vecs[k].gap_lo, vecs[k].gap_hi);
                run_len(1'b1, w);
                check("pulse_width", w, vecs[k].width);
            end
        end

        // Width select changed mid-pulse only affects the next pulse.
        uio_in = 8'b0000_1110;
        wait_for(1'b0);
        wait_for(1'b1);
        uio_in = 8'h00;
        run_len(1'b1, w);
        check("chg_cur_width", w, 8);
        run_len(1'b0, g);
        run_len(1'b1, w);
        check("chg_next_width", w, 1);

        // Reset in the middle of a W=8 pulse.
        uio_in = 8'b0000_1110;
        wait_for(1'b0);
        wait_for(1'b1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("midrst_pulse", int'(uio_out[0]), 0);
        check("midrst_count", int'(uo_out), 0);
        rst_n = 1'b0;
        first_pulse_seq();

        // Long run with random config: counter wraps and tracks rising edges.
        rst_n  = 1'b1;
        uio_in = 8'h00;
        tick();
        rst_n   = 1'b0;
        wrapped = 1'b0;
        n = 0;
        while (rises < 300 && n < 60000) begin
            if (n % 500 == 0) uio_in = 8'($urandom_range(0, 255)) & 8'h0F;
            tick();
            n++;
        end
        check("run300_done", int'(rises >= 300), 1);
        check("count_wrapped", int'(wrapped), 1);
        check("count_vs_rises", int'(uo_out), rises % 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
